audio_frame_buffer: RTL and testbench

Parametrised frame collector between the microphone sampler and the FFT. It accepts one audio sample per sample_valid strobe into a circular history of N samples. Every HOP accepted samples it snapshots the most recent N samples into a frame register. It offers the frame to the FFT through a valid/ready handshake. It replaces the fixed 16-deep shift register and the free-running start/stop toggle, adding overlap control, alignment mode, back-pressure and drop accounting.

---
 rtl/audio_frame_buffer_if.sv | 37 +++
 rtl/audio_frame_buffer.sv | 144 ++++++++++++++
 tb/tb_audio_frame_buffer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/audio_frame_buffer_if.sv
// Handshake bundle between the audio sampler/FFT side and audio_frame_buffer.
//   master : drives sample_in, sample_valid and frame_ready; observes the frame outputs.
//   slave  : the frame buffer itself.
// Signals:
//   sample_in    - signed sample, accepted when sample_valid is high
//   sample_valid - single-cycle accept strobe
//   frame_out    - N elements of OUT_W bits; element 0 is the newest sample
//   frame_valid  - frame_out holds an unconsumed frame
//   frame_ready  - consumer takes the frame when high together with frame_valid
//   overflow     - sticky "a frame was dropped" flag
//   frame_count  - delivered frames (wrapping)
//   drop_count   - dropped frames (saturating)
interface audio_frame_buffer_if #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned N        = 16,
  parameter int unsigned CNT_W    = 16
);
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic [N*OUT_W-1:0]  frame_out;
  logic                frame_valid;
  logic                frame_ready;
  logic                overflow;
  logic [CNT_W-1:0]    frame_count;
  logic [CNT_W-1:0]    drop_count;

  modport master (
    output sample_in, sample_valid, frame_ready,
    input  frame_out, frame_valid, overflow, frame_count, drop_count
  );

  modport slave (
    input  sample_in, sample_valid, frame_ready,
    output frame_out, frame_valid, overflow, frame_count, drop_count
  );
endinterface

// File: rtl/audio_frame_buffer.sv
// Frame collector between the microphone sampler and the FFT.
// Keeps a circular history of the last N accepted samples (already aligned to OUT_W).
// After the first N samples, and then every HOP samples, it snapshots the newest N
// samples (including the one accepted that cycle) into frame_out and offers it with a
// valid/ready handshake. A snapshot that finds an unconsumed frame is dropped and counted.
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   bus - audio_frame_buffer_if.slave (sample input, frame output, status counters)
// The interface instance must be built with the same SAMPLE_W/OUT_W/N/CNT_W values.
module audio_frame_buffer #(
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned N         = 16,
  parameter int unsigned HOP       = 16,
  parameter bit          ALIGN_MSB = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input logic                 clk,
  input logic                 rst,
  audio_frame_buffer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(N);

  typedef enum logic [0:0] {StFill, StRun} state_e;

  state_e              state_q;
  logic [OUT_W-1:0]    hist_q [N];
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     fill_cnt_q;
  logic [PtrW-1:0]     hop_cnt_q;
  logic [N*OUT_W-1:0]  frame_out_q;
  logic                frame_valid_q;
  logic                overflow_q;
  logic [CNT_W-1:0]    frame_count_q;
  logic [CNT_W-1:0]    drop_count_q;

  logic [OUT_W-1:0]    aligned;
  logic                snap;
  logic                handshake;
  logic [N*OUT_W-1:0]  assembled;

  initial begin
    assert (OUT_W >= SAMPLE_W) else $fatal(1, "OUT_W must be >= SAMPLE_W");
    assert (N >= 4 && N <= 256 && (N & (N - 1)) == 0) else $fatal(1, "bad N");
    assert (HOP >= 1 && HOP <= N) else $fatal(1, "bad HOP");
  end

  always_comb begin
    if (ALIGN_MSB) begin
      aligned = OUT_W'(bus.sample_in) << (OUT_W - SAMPLE_W);
    end else begin
      aligned = OUT_W'(signed'(bus.sample_in));
    end
  end

  // Snapshot is requested by the accepted sample that completes the fill or a hop.
  always_comb begin
    snap = 1'b0;
    if (bus.sample_valid) begin
      unique case (state_q)
        StFill:  snap = (fill_cnt_q == PtrW'(N - 1));
        StRun:   snap = (hop_cnt_q == PtrW'(HOP - 1));
        default: snap = 1'b0;
      endcase
    end
  end

  assign handshake = frame_valid_q && bus.frame_ready;

  // Element 0 is the sample arriving this cycle; element k (k>=1) is the k-th most
  // recently stored one. The slot at wr_ptr_q is the oldest and is being overwritten.
  always_comb begin
    assembled = '0;
    assembled[OUT_W-1:0] = aligned;
    for (int k = 1; k < int'(N); k++) begin
      assembled[k*OUT_W +: OUT_W] = hist_q[wr_ptr_q - PtrW'(k)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StFill;
      for (int i = 0; i < int'(N); i++) begin
        hist_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      fill_cnt_q    <= '0;
      hop_cnt_q     <= '0;
      frame_out_q   <= '0;
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      if (bus.sample_valid) begin
        hist_q[wr_ptr_q] <= aligned;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
        unique case (state_q)
          StFill: begin
            if (snap) begin
              state_q    <= StRun;
              fill_cnt_q <= '0;
              hop_cnt_q  <= '0;
            end else begin
              fill_cnt_q <= fill_cnt_q + 1'b1;
            end
          end
          StRun: begin
            // The hop counter restarts on every request, even a dropped one.
            hop_cnt_q <= snap ? '0 : hop_cnt_q + 1'b1;
          end
          default: state_q <= StFill;
        endcase
      end

      if (handshake) begin
        frame_count_q <= frame_count_q + 1'b1;
      end

      if (snap) begin
        if (!frame_valid_q || handshake) begin
          frame_out_q   <= assembled;
          frame_valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
          if (drop_count_q != '1) begin
            drop_count_q <= drop_count_q + 1'b1;
          end
        end
      end else if (handshake) begin
        frame_valid_q <= 1'b0;
      end
    end
  end

  assign bus.frame_out   = frame_out_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.overflow    = overflow_q;
  assign bus.frame_count = frame_count_q;
  assign bus.drop_count  = drop_count_q;

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Bench for audio_frame_buffer. Two instances share one sample stream and one reset:
//   dut_a : N=16, HOP=16, ALIGN_MSB=1
//   dut_b : N=16, HOP=4,  ALIGN_MSB=0
// Every cycle both are compared against a reference model that keeps a plain queue
// of the samples accepted since reset and derives frames from the accepted count.
module tb_audio_frame_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  audio_frame_buffer_if #(.SAMPLE_W(16), .OUT_W(32), .N(16), .CNT_W(16)) ifa ();
  audio_frame_buffer_if #(.SAMPLE_W(16), .OUT_W(32), .N(16), .CNT_W(16)) ifb ();

  audio_frame_buffer #(
    .SAMPLE_W(16), .OUT_W(32), .N(16), .HOP(16), .ALIGN_MSB(1'b1), .CNT_W(16)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(ifa)
  );

  audio_frame_buffer #(
    .SAMPLE_W(16), .OUT_W(32), .N(16), .HOP(4), .ALIGN_MSB(1'b0), .CNT_W(16)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(ifb)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [15:0]  raw [$];
  int           acc;
  logic         mv [2];
  logic [511:0] mf [2];
  logic         mo [2];
  logic [15:0]  mfc [2];
  logic [15:0]  mdc [2];

  function automatic int hop_of(int d);
    return (d == 0) ? 16 : 4;
  endfunction

  function automatic logic [31:0] align(int d, logic [15:0] s);
    if (d == 0) return {s, 16'h0000};
    return {{16{s[15]}}, s};
  endfunction

  function automatic logic [511:0] build(int d);
    logic [511:0] f = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < raw.size()) f[k*32 +: 32] = align(d, raw[k]);
    end
    return f;
  endfunction

  function automatic logic [31:0] elem(logic [511:0] f, int k);
    return f[k*32 +: 32];
  endfunction

  task automatic cmp(string nm, logic [511:0] act, logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_clear();
    raw.delete();
    acc = 0;
    for (int d = 0; d < 2; d++) begin
      mv[d] = 1'b0; mf[d] = '0; mo[d] = 1'b0; mfc[d] = '0; mdc[d] = '0;
    end
  endtask

  task automatic model_tick(logic v, logic [15:0] s, logic ra, logic rb);
    logic snap, hs, rdy;
    if (v) begin
      raw.push_front(s);
      if (raw.size() > 16) void'(raw.pop_back());
      acc++;
    end
    for (int d = 0; d < 2; d++) begin
      rdy  = (d == 0) ? ra : rb;
      snap = v && (acc == 16 || (acc > 16 && (acc - 16) % hop_of(d) == 0));
      hs   = mv[d] && rdy;
      if (hs) mfc[d] = mfc[d] + 16'd1;
      if (snap) begin
        if (!mv[d] || hs) begin
          mf[d] = build(d);
          mv[d] = 1'b1;
        end else begin
          mo[d] = 1'b1;
          if (mdc[d] != 16'hFFFF) mdc[d] = mdc[d] + 16'd1;
        end
      end else if (hs) begin
        mv[d] = 1'b0;
      end
    end
  endtask

  task automatic compare_all(string tag);
    cmp({tag, " a.valid"}, 512'(ifa.frame_valid), 512'(mv[0]));
    cmp({tag, " a.frame"}, ifa.frame_out, mf[0]);
    cmp({tag, " a.ovf"},   512'(ifa.overflow), 512'(mo[0]));
    cmp({tag, " a.fcnt"},  512'(ifa.frame_count), 512'(mfc[0]));
    cmp({tag, " a.dcnt"},  512'(ifa.drop_count), 512'(mdc[0]));
    cmp({tag, " b.valid"}, 512'(ifb.frame_valid), 512'(mv[1]));
    cmp({tag, " b.frame"}, ifb.frame_out, mf[1]);
    cmp({tag, " b.ovf"},   512'(ifb.overflow), 512'(mo[1]));
    cmp({tag, " b.fcnt"},  512'(ifb.frame_count), 512'(mfc[1]));
    cmp({tag, " b.dcnt"},  512'(ifb.drop_count), 512'(mdc[1]));
  endtask

  task automatic step(string tag, logic v, logic [15:0] s, logic ra, logic rb);
    ifa.sample_valid = v;  ifb.sample_valid = v;
    ifa.sample_in    = s;  ifb.sample_in    = s;
    ifa.frame_ready  = ra; ifb.frame_ready  = rb;
    @(posedge clk);
    model_tick(v, s, ra, rb);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    ifa.sample_valid = 1'b0; ifb.sample_valid = 1'b0;
    ifa.frame_ready  = 1'b0; ifb.frame_ready  = 1'b0;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all("reset");
    cmp("reset a.fcnt", 512'(ifa.frame_count), 512'(0));
    cmp("reset b.frame", ifb.frame_out, 512'(0));
  endtask

  // Feed samples lo..hi (value = index) with fixed readies.
  task automatic feed(string tag, int lo, int hi, logic ra, logic rb);
    for (int i = lo; i <= hi; i++) step(tag, 1'b1, 16'(i), ra, rb);
  endtask

  typedef struct {
    logic [15:0] s;
    logic [31:0] exp_msb;
    logic [31:0] exp_sext;
  } sign_vec_t;

  sign_vec_t sv [4];

  initial begin
    sv[0] = '{16'h8000, 32'h8000_0000, 32'hFFFF_8000};
    sv[1] = '{16'h7FFF, 32'h7FFF_0000, 32'h0000_7FFF};
    sv[2] = '{16'hFFFF, 32'hFFFF_0000, 32'hFFFF_FFFF};
    sv[3] = '{16'h0001, 32'h0001_0000, 32'h0000_0001};

    ifa.sample_in = '0; ifb.sample_in = '0;
    model_clear();
    do_reset();

    // Fill: nothing until the 16th sample, then newest/oldest elements in place.
    feed("fill", 1, 15, 1'b0, 1'b0);
    cmp("fill15 a.valid", 512'(ifa.frame_valid), 512'(0));
    step("fill16", 1'b1, 16'd16, 1'b0, 1'b0);
    cmp("fill a.valid", 512'(ifa.frame_valid), 512'(1));
    cmp("fill a.e0", 512'(elem(ifa.frame_out, 0)), 512'(32'h0010_0000));
    cmp("fill a.e15", 512'(elem(ifa.frame_out, 15)), 512'(32'h0001_0000));

    // Overlap with HOP=4 and a consumer that is always ready.
    do_reset();
    feed("ovl", 1, 24, 1'b1, 1'b1);
    cmp("ovl b.e0", 512'(elem(ifb.frame_out, 0)), 512'(32'd24));
    cmp("ovl b.e15", 512'(elem(ifb.frame_out, 15)), 512'(32'd9));
    step("ovl idle", 1'b0, 16'd0, 1'b1, 1'b1);
    cmp("ovl b.fcnt", 512'(ifb.frame_count), 512'(3));
    cmp("ovl b.valid", 512'(ifb.frame_valid), 512'(0));

    // Back-pressure: two dropped snapshots, first frame retained.
    do_reset();
    feed("bp", 1, 24, 1'b0, 1'b0);
    cmp("bp b.dcnt", 512'(ifb.drop_count), 512'(2));
    cmp("bp b.ovf", 512'(ifb.overflow), 512'(1));
    cmp("bp b.e0", 512'(elem(ifb.frame_out, 0)), 512'(32'd16));
    cmp("bp b.e15", 512'(elem(ifb.frame_out, 15)), 512'(32'd1));

    // Snapshot and handshake on the same edge.
    do_reset();
    feed("sim", 1, 19, 1'b0, 1'b0);
    step("sim20", 1'b1, 16'd20, 1'b0, 1'b1);
    cmp("sim b.valid", 512'(ifb.frame_valid), 512'(1));
    cmp("sim b.e0", 512'(elem(ifb.frame_out, 0)), 512'(32'd20));
    cmp("sim b.ovf", 512'(ifb.overflow), 512'(0));
    cmp("sim b.fcnt", 512'(ifb.frame_count), 512'(1));

    // Sign handling / alignment table.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      for (int j = 0; j < 15; j++) step("sign pad", 1'b1, 16'h0000, 1'b0, 1'b0);
      step("sign", 1'b1, sv[i].s, 1'b0, 1'b0);
      cmp($sformatf("sign%0d a.e0", i), 512'(elem(ifa.frame_out, 0)), 512'(sv[i].exp_msb));
      cmp($sformatf("sign%0d b.e0", i), 512'(elem(ifb.frame_out, 0)), 512'(sv[i].exp_sext));
    end

    // Reset mid-operation discards partial history and counters.
    do_reset();
    feed("mid pre", 100, 109, 1'b1, 1'b1);
    do_reset();
    feed("mid", 1, 16, 1'b0, 1'b0);
    cmp("mid a.e0", 512'(elem(ifa.frame_out, 0)), 512'(32'h0010_0000));
    cmp("mid a.e15", 512'(elem(ifa.frame_out, 15)), 512'(32'h0001_0000));
    cmp("mid b.e15", 512'(elem(ifb.frame_out, 15)), 512'(32'd1));
    cmp("mid b.fcnt", 512'(ifb.frame_count), 512'(0));
    step("mid hs", 1'b0, 16'd0, 1'b1, 1'b1);
    cmp("mid a.fcnt", 512'(ifa.frame_count), 512'(1));

    // Randomised traffic against the model, with one reset in the middle.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      step("rnd", ($urandom_range(0, 9) < 7), 16'($urandom),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
